// File: rtl/sdiv_pkg.sv
// Shared types and sizing helpers for the sequential signed divider.
package sdiv_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        OUT  = 2'd3
    } state_e;

    // The step counter must be able to reach WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

endpackage

// File: rtl/sdiv_if.sv
// Request/result bundle between a divider client (master) and sdiv_seq (slave).
interface sdiv_if
    import sdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    // Handshake: start is sampled only while the divider is idle (busy=0);
    // dvdnd/dvsor are captured on that edge. valid pulses for exactly one
    // cycle when quot/remd/div_zero/ovf are good; they then hold until the
    // next valid. A start seen while busy=1 is dropped, not queued.
    logic                 start;
    logic [2*WIDTH-1:0]   dvdnd;
    logic [WIDTH-1:0]     dvsor;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     remd;
    logic                 busy;
    logic                 valid;
    logic                 div_zero;
    logic                 ovf;

    modport master (
        output start, dvdnd, dvsor,
        input  quot, remd, busy, valid, div_zero, ovf
    );

    modport slave (
        input  start, dvdnd, dvsor,
        output quot, remd, busy, valid, div_zero, ovf
    );

endinterface

// File: rtl/sdiv_step.sv
// One restoring-division step: (WIDTH+1)-bit ripple trial subtract of the
// divisor magnitude from the shifted partial remainder, plus restore mux.
module sdiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] dvs_inv;
    logic [WIDTH:0] diff;
    logic           carry;
    logic           unused_diff_msb;

    assign shifted = {rem_i, bit_i};
    assign dvs_inv = ~{1'b0, dvs_i};

    // Ripple of full-adder cells; carry-out of 1 means the difference is non-negative.
    always_comb begin
        carry = 1'b1;
        diff  = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            diff[i] = shifted[i] ^ dvs_inv[i] ^ carry;
            carry   = (shifted[i] & dvs_inv[i]) | (carry & (shifted[i] ^ dvs_inv[i]));
        end
        qbit_o = carry;
        rem_o  = carry ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

    assign unused_diff_msb = diff[WIDTH];

endmodule

// File: rtl/sdiv_seq.sv
// Sequential signed divider, 2*WIDTH / WIDTH bits, one restoring step per clock.
// Quotient truncates toward zero; remainder follows the dividend's sign.
module sdiv_seq
    import sdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic       clock,
    input  logic       reset,
    sdiv_if.slave      bus,
    output logic [1:0] state_dbg
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_DIV  = DIV;
    localparam logic [1:0] S_FIX  = FIX;
    localparam logic [1:0] S_OUT  = OUT;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic               err_z_q, err_z_d;
    logic               err_o_q, err_o_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   remd_q, remd_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               dz_q, dz_d;
    logic               ovf_q, ovf_d;

    logic [2*WIDTH-1:0] dvdnd_mag;
    logic [WIDTH-1:0]   dvsor_mag;
    logic [WIDTH-1:0]   step_rem;
    logic               step_qbit;
    logic [WIDTH-1:0]   q_signed;
    logic [WIDTH-1:0]   r_signed;
    logic               late_ovf;
    logic               ovf_fix;

    assign dvdnd_mag = bus.dvdnd[2*WIDTH-1] ? -bus.dvdnd : bus.dvdnd;
    assign dvsor_mag = bus.dvsor[WIDTH-1]   ? -bus.dvsor : bus.dvsor;

    sdiv_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .bit_i  (lo_q[WIDTH-1]),
        .dvs_i  (dvs_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    // A negative result may reach -2^(WIDTH-1); a positive one only 2^(WIDTH-1)-1.
    assign q_signed = qneg_q ? -lo_q  : lo_q;
    assign r_signed = rneg_q ? -rem_q : rem_q;
    assign late_ovf = qneg_q ? (lo_q[WIDTH-1] && (|lo_q[WIDTH-2:0])) : lo_q[WIDTH-1];
    assign ovf_fix  = !err_z_q && (err_o_q || late_ovf);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        lo_d    = lo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        err_z_d = err_z_q;
        err_o_d = err_o_q;
        quot_d  = quot_q;
        remd_d  = remd_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_DIV;
                    cnt_d   = '0;
                    rem_d   = dvdnd_mag[2*WIDTH-1:WIDTH];
                    lo_d    = dvdnd_mag[WIDTH-1:0];
                    dvs_d   = dvsor_mag;
                    qneg_d  = bus.dvdnd[2*WIDTH-1] ^ bus.dvsor[WIDTH-1];
                    rneg_d  = bus.dvdnd[2*WIDTH-1];
                    err_z_d = (bus.dvsor == '0);
                    // Upper half >= divisor means the unsigned quotient needs > WIDTH bits.
                    err_o_d = (bus.dvsor != '0) && (dvdnd_mag[2*WIDTH-1:WIDTH] >= dvsor_mag);
                end
            end
            S_DIV: begin
                rem_d = step_rem;
                lo_d  = {lo_q[WIDTH-2:0], step_qbit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_OUT;
                valid_d = 1'b1;
                dz_d    = err_z_q;
                ovf_d   = ovf_fix;
                if (err_z_q || ovf_fix) begin
                    quot_d = '0;
                    remd_d = '0;
                end else begin
                    quot_d = q_signed;
                    remd_d = r_signed;
                end
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            lo_q    <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            err_z_q <= 1'b0;
            err_o_q <= 1'b0;
            quot_q  <= '0;
            remd_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            lo_q    <= lo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            err_z_q <= err_z_d;
            err_o_q <= err_o_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.quot     = quot_q;
    assign bus.remd     = remd_q;
    assign bus.busy     = busy_q;
    assign bus.valid    = valid_q;
    assign bus.div_zero = dz_q;
    assign bus.ovf      = ovf_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_sdiv_seq.sv
// Bench for sdiv_seq: directed cases plus random operands against a wide
// signed-arithmetic reference.
module tb_sdiv_seq;

    localparam int W = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] state_dbg;
    int         checks = 0;
    int         failures = 0;

    sdiv_if #(.WIDTH(W)) bus ();

    sdiv_seq #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact signed division on 66-bit values, then range check.
    function automatic void ref_div(input logic [63:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz, output logic ov);
        logic signed [65:0] sa, sb, sq, sr;
        dz = (b == 32'd0);
        ov = 1'b0;
        q  = '0;
        r  = '0;
        if (!dz) begin
            sa = {{2{a[63]}}, a};
            sb = {{34{b[31]}}, b};
            sq = sa / sb;
            sr = sa % sb;
            ov = (sq > 66'sd2147483647) || (sq < -66'sd2147483648);
            if (!ov) begin
                q = sq[31:0];
                r = sr[31:0];
            end
        end
    endfunction

    task automatic wait_valid(input int limit, output int cyc);
        cyc = 0;
        do begin
            @(posedge clock);
            #1;
            cyc++;
        end while (!bus.valid && cyc < limit);
    endtask

    task automatic run_div(input string tag, input logic [63:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        logic        edz, eov;
        int          cyc;
        ref_div(a, b, eq, er, edz, eov);
        @(negedge clock);
        bus.dvdnd = a;
        bus.dvsor = b;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        chk({tag, ".busy_at_accept"}, bus.busy, 1);
        @(negedge clock);
        bus.start = 1'b0;
        wait_valid(60, cyc);
        chk({tag, ".valid"}, bus.valid, 1);
        chk({tag, ".latency"}, cyc, 33);
        chk({tag, ".quot"}, bus.quot, eq);
        chk({tag, ".remd"}, bus.remd, er);
        chk({tag, ".div_zero"}, bus.div_zero, edz);
        chk({tag, ".ovf"}, bus.ovf, eov);
        @(posedge clock);
        #1;
        chk({tag, ".valid_one_cycle"}, bus.valid, 0);
        chk({tag, ".busy_drop"}, bus.busy, 0);
        chk({tag, ".quot_hold"}, bus.quot, eq);
    endtask

    initial begin
        int          cyc;
        int          seen;
        int          qi, ri, mode;
        logic [31:0] b;
        logic [63:0] a;
        longint      p;

        bus.start = 1'b0;
        bus.dvdnd = '0;
        bus.dvsor = '0;

        repeat (3) @(posedge clock);
        #1;
        chk("reset.quot", bus.quot, 0);
        chk("reset.remd", bus.remd, 0);
        chk("reset.busy", bus.busy, 0);
        chk("reset.valid", bus.valid, 0);
        chk("reset.div_zero", bus.div_zero, 0);
        chk("reset.ovf", bus.ovf, 0);
        @(negedge clock);
        reset = 1'b1;

        run_div("p100_7", 64'd100, 32'd7);
        chk("p100_7.quot_const", bus.quot, 32'd14);
        chk("p100_7.remd_const", bus.remd, 32'd2);

        run_div("n100_7", 64'hFFFF_FFFF_FFFF_FF9C, 32'd7);
        chk("n100_7.quot_const", bus.quot, 32'hFFFF_FFF2);
        chk("n100_7.remd_const", bus.remd, 32'hFFFF_FFFE);

        run_div("p100_n7", 64'd100, 32'hFFFF_FFF9);
        chk("p100_n7.quot_const", bus.quot, 32'hFFFF_FFF2);
        chk("p100_n7.remd_const", bus.remd, 32'd2);

        run_div("div0", 64'd12345, 32'd0);
        chk("div0.dz_const", bus.div_zero, 1);
        chk("div0.ovf_const", bus.ovf, 0);

        run_div("ovf_early", 64'h0000_0001_0000_0000, 32'd1);
        chk("ovf_early.const", bus.ovf, 1);
        run_div("ovf_late", 64'h0000_0000_8000_0000, 32'd1);
        chk("ovf_late.const", bus.ovf, 1);
        run_div("min_neg", 64'hFFFF_FFFF_8000_0000, 32'd1);
        chk("min_neg.quot_const", bus.quot, 32'h8000_0000);
        chk("min_neg.ovf_const", bus.ovf, 0);
        run_div("min_by_m1", 64'hFFFF_FFFF_8000_0000, 32'hFFFF_FFFF);
        chk("min_by_m1.ovf_const", bus.ovf, 1);

        // Abort mid-operation with an asynchronous reset.
        @(negedge clock);
        bus.dvdnd = 64'd1000;
        bus.dvsor = 32'd3;
        bus.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (9) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("abort.quot", bus.quot, 0);
        chk("abort.remd", bus.remd, 0);
        chk("abort.busy", bus.busy, 0);
        chk("abort.valid", bus.valid, 0);
        chk("abort.ovf", bus.ovf, 0);
        @(negedge clock);
        reset = 1'b1;
        seen = 0;
        repeat (45) begin
            @(posedge clock);
            #1;
            if (bus.valid) seen++;
        end
        chk("abort.no_valid", seen, 0);
        run_div("after_rst", 64'd50, 32'd5);
        chk("after_rst.quot_const", bus.quot, 32'd10);
        chk("after_rst.remd_const", bus.remd, 32'd0);

        // Held start: ignored while busy, re-accepted in the IDLE cycle after OUT.
        @(negedge clock);
        bus.dvdnd = 64'd1000;
        bus.dvsor = 32'd3;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        wait_valid(60, cyc);
        chk("held.latency", cyc, 33);
        chk("held.quot", bus.quot, 32'd333);
        chk("held.remd", bus.remd, 32'd1);
        @(negedge clock);
        bus.dvdnd = 64'd9;
        bus.dvsor = 32'd2;
        wait_valid(60, cyc);
        chk("b2b.valid", bus.valid, 1);
        chk("b2b.spacing", cyc, 35);
        chk("b2b.quot", bus.quot, 32'd4);
        chk("b2b.remd", bus.remd, 32'd1);
        @(negedge clock);
        bus.start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("b2b.idle_after", bus.busy, 0);

        for (int n = 0; n < 24; n++) begin
            mode = $urandom_range(0, 3);
            b = $urandom;
            if (mode == 3) b = $urandom_range(0, 15);
            qi = int'($urandom) >>> $urandom_range(1, 20);
            ri = int'($urandom_range(0, 1000));
            if (mode == 1) begin
                a = {$urandom, $urandom};
            end else if (mode == 2) begin
                p = longint'(qi) * longint'(int'(b)) + longint'(ri);
                a = p;
            end else begin
                a = {{32{qi[31]}}, qi};
            end
            run_div($sformatf("rnd%0d", n), a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
